// File: rtl/i2s_tx.sv
// I2S master transmitter: divides HCLK down to BCLK, frames stereo samples from a small
// internal FIFO and shifts them out MSB first with the standard one-BCLK WS delay.
module i2s_tx #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SLOT_W     = 32,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          en,
  input  logic [2*DATA_W-1:0]           wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          i2s_clk,
  output logic                          ws,
  output logic                          sd_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(2 * SLOT_W);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BMAX = BW'(2 * SLOT_W - 1);

  logic [2*DATA_W-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic                full, empty, push, pop;

  logic                active_q, active_d;
  logic [DW-1:0]       div_q, div_d;
  logic                clk_q, clk_d;
  logic [BW-1:0]       b_q, b_d;
  logic [DATA_W-1:0]   left_q, left_d, right_q, right_d;
  logic                ws_q, ws_d, sd_q, sd_d, under_q, under_d;
  logic                load, bit_start, sel;
  logic [BW-1:0]       p, bn;
  logic [IW-1:0]       idx;
  logic [DATA_W-1:0]   word;

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  // Held low during reset so nothing is written into a FIFO being cleared.
  assign wr_ready = !HRESET && !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = load && !empty;

  always_comb begin
    active_d  = active_q;
    div_d     = div_q;
    clk_d     = clk_q;
    b_d       = b_q;
    left_d    = left_q;
    right_d   = right_q;
    ws_d      = ws_q;
    sd_d      = sd_q;
    load      = 1'b0;
    bit_start = 1'b0;
    sel       = 1'b0;
    p         = '0;
    bn        = '0;
    idx       = '0;
    word      = '0;

    if (!en) begin
      active_d = 1'b0;
      div_d    = '0;
      clk_d    = 1'b0;
      b_d      = '0;
      ws_d     = 1'b0;
      sd_d     = 1'b0;
    end else if (!active_q) begin
      active_d  = 1'b1;
      div_d     = '0;
      clk_d     = 1'b0;
      b_d       = '0;
      load      = 1'b1;
      bit_start = 1'b1;
    end else if (div_q == DW'(CLK_DIV - 1)) begin
      div_d = '0;
      clk_d = !clk_q;
      if (clk_q) begin
        b_d       = (b_q == BMAX) ? '0 : b_q + 1'b1;
        load      = (b_d == '0);
        bit_start = 1'b1;
      end
    end else begin
      div_d = div_q + 1'b1;
    end

    if (load) begin
      {left_d, right_d} = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Outputs for the new bit are computed from next-state values so they appear
    // together with the bit-start edge and stay stable across the rising edge.
    if (bit_start) begin
      sel  = (b_d >= BW'(SLOT_W));
      p    = sel ? b_d - BW'(SLOT_W) : b_d;
      bn   = (b_d == BMAX) ? '0 : b_d + 1'b1;
      ws_d = (bn >= BW'(SLOT_W));
      word = sel ? right_d : left_d;
      idx  = IW'(DATA_W - 1) - IW'(p);
      sd_d = (p < BW'(DATA_W)) ? word[idx] : 1'b0;
    end
  end

  assign under_d = load && empty;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      active_q <= 1'b0;
      div_q    <= '0;
      clk_q    <= 1'b0;
      b_q      <= '0;
      left_q   <= '0;
      right_q  <= '0;
      ws_q     <= 1'b0;
      sd_q     <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      active_q <= active_d;
      div_q    <= div_d;
      clk_q    <= clk_d;
      b_q      <= b_d;
      left_q   <= left_d;
      right_q  <= right_d;
      ws_q     <= ws_d;
      sd_q     <= sd_d;
      under_q  <= under_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign i2s_clk    = clk_q;
  assign ws         = ws_q;
  assign sd_out     = sd_q;
  assign underrun   = under_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: an I2S receiver sampling on BCLK rising edges is compared against
// a queue of written stereo entries.
module tb_i2s_tx;
  localparam int DATA_W = 16;
  localparam int SLOT_W = 32;
  localparam int CLK_DIV = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int FRAME = 2 * SLOT_W * 2 * CLK_DIV;

  logic        HCLK, HRESET, en, wr_valid, wr_ready, i2s_clk, ws, sd_out, underrun;
  logic [31:0] wr_data;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] cur;

  i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .i2s_clk(i2s_clk), .ws(ws), .sd_out(sd_out),
    .fifo_level(fifo_level), .underrun(underrun)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Reference receiver: observes one frame from its first cycle (offset 0) to offset FRAME-1.
  task automatic capture(output logic [15:0] l, output logic [15:0] r, output int upulse,
                         output int first_up, output int rises, output int first_rise,
                         output int ws_bad, output int pad_bad);
    logic prev_clk;
    int b, p;
    l = '0; r = '0; upulse = 0; first_up = -1; rises = 0; first_rise = -1;
    ws_bad = 0; pad_bad = 0; prev_clk = 1'b1;
    for (int off = 0; off < FRAME; off++) begin
      if (off > 0) begin
        tick();
        wr_valid = 1'b0;
      end
      if (underrun === 1'b1) begin
        upulse++;
        if (first_up < 0) first_up = off;
      end
      if (i2s_clk === 1'b1 && prev_clk === 1'b0) begin
        b = rises;
        if (first_rise < 0) first_rise = off;
        if (ws !== 1'(((b + 1) % (2 * SLOT_W)) >= SLOT_W)) ws_bad++;
        p = b % SLOT_W;
        if (p < DATA_W) begin
          if (b < SLOT_W) l[DATA_W-1-p] = sd_out;
          else            r[DATA_W-1-p] = sd_out;
        end else if (sd_out !== 1'b0) begin
          pad_bad++;
        end
        rises++;
      end
      prev_clk = i2s_clk;
    end
  endtask

  task automatic offer(input logic [31:0] d);
    logic exp_rdy;
    exp_rdy = (q.size() < FIFO_DEPTH);
    wr_valid = 1'b1;
    wr_data = d;
    #1;
    checks++;
    if (wr_ready !== exp_rdy) begin
      errors++;
      $display("FAIL offer_ready got %b want %b", wr_ready, exp_rdy);
    end
    tick();
    wr_valid = 1'b0;
    if (exp_rdy) q.push_back(d);
  endtask

  task automatic test_reset;
    HRESET = 1'b1; en = 1'b0; wr_valid = 1'b1; wr_data = $urandom;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({i2s_clk, ws, sd_out, underrun, wr_ready} !== 5'b0 || fifo_level !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs got clk/ws/sd/un/rdy %b%b%b%b%b level %0d want 0",
                 i2s_clk, ws, sd_out, underrun, wr_ready, fifo_level);
      end
    end
    HRESET = 1'b0; wr_valid = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_release got rdy %b level %0d want rdy 1 level 0", wr_ready, fifo_level);
    end
  endtask

  task automatic check_frame(input string name, input logic [31:0] exp, input int exp_up);
    logic [15:0] l, r;
    int up, fu, rs, fr, wb, pb;
    capture(l, r, up, fu, rs, fr, wb, pb);
    checks++;
    if ({l, r} !== exp) begin
      errors++;
      $display("FAIL %s_data got %h_%h want %h", name, l, r, exp);
    end
    checks++;
    if (up !== exp_up || (exp_up == 1 && fu !== 0)) begin
      errors++;
      $display("FAIL %s_underrun got %0d pulses at %0d want %0d at 0", name, up, fu, exp_up);
    end
    checks++;
    if (rs !== 2 * SLOT_W || fr !== CLK_DIV) begin
      errors++;
      $display("FAIL %s_bclk got %0d rises first %0d want %0d first %0d",
               name, rs, fr, 2 * SLOT_W, CLK_DIV);
    end
    checks++;
    if (wb !== 0 || pb !== 0) begin
      errors++;
      $display("FAIL %s_ws_pad got ws_bad %0d pad_bad %0d want 0 0", name, wb, pb);
    end
  endtask

  task automatic start_frame;
    if (q.size() > 0) cur = q.pop_front();
    else cur = '0;
  endtask

  task automatic stop_and_check_idle(input string name);
    en = 1'b0;
    tick();
    checks++;
    if ({i2s_clk, ws, sd_out} !== 3'b0 || fifo_level !== 3'(q.size())) begin
      errors++;
      $display("FAIL %s_idle got clk/ws/sd %b%b%b level %0d want 000 level %0d",
               name, i2s_clk, ws, sd_out, fifo_level, q.size());
    end
  endtask

  task automatic test_single_frame;
    offer(32'hA5A5_3C3C);
    en = 1'b1;
    tick();
    start_frame();
    check_frame("single", cur, 0);
    stop_and_check_idle("single");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) offer($urandom);
    en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      tick();
      start_frame();
      check_frame("b2b", cur, 0);
    end
    stop_and_check_idle("b2b");
  endtask

  task automatic test_underrun;
    int total = 0;
    en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      tick();
      start_frame();
      checks++;
      if (underrun !== 1'b1) begin
        errors++;
        $display("FAIL underrun_start got %b want 1", underrun);
      end else total++;
      check_frame("underrun", 32'h0, 1);
    end
    checks++;
    if (total !== 3) begin
      errors++;
      $display("FAIL underrun_total got %0d want 3", total);
    end
    stop_and_check_idle("underrun");
  endtask

  task automatic test_backpressure;
    logic [31:0] d5;
    for (int i = 0; i < 4; i++) offer($urandom);
    d5 = $urandom;
    wr_valid = 1'b1; wr_data = d5; en = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_state got rdy %b level %0d want rdy 0 level 4", wr_ready, fifo_level);
    end
    tick();
    start_frame();
    checks++;
    if (wr_ready !== 1'b1 || fifo_level !== 3'(q.size())) begin
      errors++;
      $display("FAIL full_pop got rdy %b level %0d want rdy 1 level %0d",
               wr_ready, fifo_level, q.size());
    end
    q.push_back(d5);
    check_frame("bp", cur, 0);
    checks++;
    if (fifo_level !== 3'(q.size())) begin
      errors++;
      $display("FAIL bp_level got %0d want %0d", fifo_level, q.size());
    end
    for (int f = 0; f < 4; f++) begin
      tick();
      start_frame();
      check_frame("bp", cur, 0);
    end
    stop_and_check_idle("bp");
  endtask

  task automatic test_abort;
    offer($urandom);
    offer($urandom);
    en = 1'b1;
    tick();
    start_frame();
    repeat (20 * 2 * CLK_DIV) tick();
    stop_and_check_idle("abort");
    en = 1'b1;
    tick();
    start_frame();
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL abort_restart_level got %0d want 0", fifo_level);
    end
    check_frame("abort", cur, 0);
    stop_and_check_idle("abort_end");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) offer($urandom);
    en = 1'b1;
    tick();
    start_frame();
    repeat (40 * 2 * CLK_DIV) tick();
    HRESET = 1'b1;
    tick();
    q.delete();
    checks++;
    if ({i2s_clk, ws, sd_out, underrun, wr_ready} !== 5'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid got clk/ws/sd/un/rdy %b%b%b%b%b level %0d want 0",
               i2s_clk, ws, sd_out, underrun, wr_ready, fifo_level);
    end
    HRESET = 1'b0;
    tick();
    start_frame();
    check_frame("reset_mid", 32'h0, 1);
    stop_and_check_idle("reset_mid");
  endtask

  initial begin
    HRESET = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; cur = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S master transmitter: generates BCLK (i2s_clk) and WS from HCLK, and serialises stereo samples on sd_out.
- Samples come from an internal FIFO written by the SoC's peripheral logic.
- Same I2S framing as the SoC's I2S receive path, so the two loop back directly for self-test.
- Planned use: audio/feedback output from the Hazard2 SoC.

Parameters:
- DATA_W, 16: bits per channel sample.
- SLOT_W, 32: BCLK periods per channel slot. Must be >= DATA_W + 1.
- CLK_DIV, 4: HCLK cycles per BCLK half-period. Must be >= 1.
- FIFO_DEPTH, 4: stereo entries in FIFO. Must be a power of 2.

Ports:
- HCLK  in  1  sole clock.
- HRESET  in  1  synchronous reset, active-high.
- en  in  1  transmit enable.
- wr_data  in  2*DATA_W  stereo entry: [2*DATA_W-1:DATA_W] = left, [DATA_W-1:0] = right.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept; a write occurs when wr_valid && wr_ready.
- i2s_clk  out  1  BCLK.
- ws  out  1  word select: 0 = left, 1 = right.
- sd_out  out  1  serial data.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held.
- underrun  out  1  one-HCLK pulse on frame start with empty FIFO.

Behaviour:
- Reset (sampled on HCLK edge while HRESET=1):
  - i2s_clk, ws, sd_out, underrun = 0.
  - fifo_level = 0; FIFO empty.
  - wr_ready = 0 while HRESET=1, and 1 on the first cycle after HRESET deasserts.
  - Reset mid-frame aborts the frame and discards all FIFO contents.
- FIFO:
  - wr_ready = !full.
  - A push while full cannot occur, even if a pop happens in the same cycle; wr_ready is combinational on full only.
  - Push and pop in the same cycle: fifo_level unchanged.
  - Pop from empty does not change the level.
  - Writes are accepted regardless of en.
- Idle (en=0): i2s_clk, ws, sd_out held 0; divider and bit counter held at 0; no pops.
- Start: the first HCLK cycle with en=1 while idle is "bit 0" of a frame.
  - From then, BCLK toggles every CLK_DIV HCLK cycles: first rising edge CLK_DIV cycles after start, first falling edge 2*CLK_DIV cycles after start.
- Bit counter b, 0..2*SLOT_W-1:
  - Advances on every BCLK falling edge (the HCLK cycle in which i2s_clk goes 1->0).
  - Wraps to 0 after 2*SLOT_W-1.
  - ws and sd_out change only in bit-start cycles (start, or falling edge), so they are stable across each rising edge.
- Frame load, at bit-start with b=0:
  - Pop one entry into the left and right shift registers.
  - If the FIFO is empty: load zeros and pulse underrun for that cycle.
- ws: for bit b, ws = 1 iff ((b+1) mod 2*SLOT_W) >= SLOT_W.
  - ws rises at b=SLOT_W-1 and falls at b=2*SLOT_W-1, one BCLK before the MSB of the next slot (standard I2S delay).
- sd_out for bit b, with p = b mod SLOT_W:
  - b < SLOT_W: left[DATA_W-1-p] if p < DATA_W, else 0.
  - b >= SLOT_W: right[DATA_W-1-p] if p < DATA_W, else 0.
  - MSB first.
- Frame period = 2*SLOT_W*2*CLK_DIV HCLK cycles.
- en deasserted mid-frame:
  - Next HCLK cycle: return to idle (outputs 0, counters 0).
  - The popped entry is discarded.
  - Re-enable starts a new frame at b=0 with a fresh pop.
- Registered outputs; no combinational path from inputs to i2s_clk/ws/sd_out.

Test Plan:
All scenarios use DATA_W=16, SLOT_W=32, CLK_DIV=2, FIFO_DEPTH=4 (frame = 256 HCLK); a reference I2S receiver samples on i2s_clk rising edges.
- Reset: hold HRESET=1 for 5 cycles with wr_valid=1 -> all outputs 0, fifo_level=0, no write accepted. After release -> wr_ready=1.
- Single frame: write 32'hA5A5_3C3C, then en=1 ->
  - ws=0 for bits 0..30, 1 for bits 31..62, 0 at bit 63.
  - Receiver captures left=16'hA5A5, right=16'h3C3C; bits 16..31 and 48..63 are 0.
  - First rising i2s_clk 2 HCLK after start; underrun never pulses.
- Underrun: en=1 with empty FIFO for 3 frames -> sd_out constantly 0, ws toggles normally, underrun pulses exactly once per frame (3 pulses, 256 HCLK apart).
- Full/backpressure: en=0, offer 5 writes back-to-back ->
  - 4 accepted, fifo_level=4, wr_ready=0.
  - After en=1, the start-cycle pop gives level 3 and wr_ready=1; the 5th write is accepted the next cycle.
  - Frames output entries in write order.
- Abort: en=0 at b=20 of a frame with 2 entries queued -> next cycle i2s_clk/ws/sd_out = 0. Re-enable -> frame restarts at b=0 carrying the second entry; level goes 1->0.
- Reset mid-frame: HRESET=1 at b=40 with 3 entries queued -> next cycle outputs 0, fifo_level=0. With en=1 after release, the following frame transmits zeros and pulses underrun.
